i2s_tx_ctrl: RTL

- CPU-fed audio transmitter for the MAX9850 DAC. Replaces the free-running tone path.
- Buffers stereo samples in a FIFO and generates MCLK, BCLK and LRCLK.
- Serialises samples in left-justified format, MSB first, 16 bits per channel, 32 BCLKs per frame.
- Sits on the CPU memory-mapped bus next to the GPIO and I2C blocks; the CPU configures the DAC over I2C and streams samples through this block.

---
 rtl/i2s_tx_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/i2s_tx_ctrl.sv
// CPU-fed left-justified I2S transmitter for the MAX9850: sample FIFO plus MCLK/BCLK/LRCLK/SDIN generation.
// Optional I2S_TX_HOLD_LAST_EN: an empty-FIFO frame load repeats the last popped frame instead of zeros.
module i2s_tx_ctrl #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int BCLK_DIV_LOG2   = 3
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       wr_valid,
    input  logic [31:0]                wr_data,
    output logic                       wr_ready,
    input  logic                       enable,
    input  logic                       mute,
    input  logic [FIFO_DEPTH_LOG2:0]   watermark,
    input  logic                       clr_underrun,
    output logic [FIFO_DEPTH_LOG2:0]   level,
    output logic                       underrun,
    output logic                       irq,
    output logic                       MCLK,
    output logic                       BCLK,
    output logic                       LRCLK,
    output logic                       SDIN
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int LW    = FIFO_DEPTH_LOG2 + 1;
    localparam int CW    = BCLK_DIV_LOG2 + 6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                     state_q;
    logic [CW-1:0]              cnt_q;
    logic [31:0]                shift_q;
    logic                       mclk_q;
    logic [LW-1:0]              level_q, level_d;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic                       underrun_q, underrun_d;
    logic                       irq_q;
    logic [31:0]                mem [DEPTH];

    logic        cnt_max, bit_end;
    logic        load, fifo_empty, push, pop;
    logic [31:0] rd_entry, load_data;

`ifdef I2S_TX_HOLD_LAST_EN
    logic [31:0] last_q;
`endif

    // Write handshake: a word is taken on any clock where wr_valid && wr_ready;
    // wr_ready depends only on the registered level, never on wr_valid.
    assign wr_ready = (level_q != LW'(DEPTH));

    always_comb begin
        cnt_max    = &cnt_q;
        bit_end    = &cnt_q[BCLK_DIV_LOG2:0];
        load       = enable && ((state_q == S_IDLE) || cnt_max);
        fifo_empty = (level_q == '0);
        push       = wr_valid && wr_ready;
        pop        = load && !fifo_empty;
        rd_entry   = mem[rd_ptr_q];

        load_data = '0;
        if (!mute) begin
            if (pop) begin
                load_data = rd_entry;
            end else begin
`ifdef I2S_TX_HOLD_LAST_EN
                load_data = last_q;
`else
                load_data = '0;
`endif
            end
        end

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A set from an empty load wins over a same-cycle clear.
        underrun_d = underrun_q;
        if (load && fifo_empty) begin
            underrun_d = 1'b1;
        end else if (clr_underrun) begin
            underrun_d = 1'b0;
        end
    end

    // Frame sequencer; cnt wraps naturally from all-ones to zero on a reload.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (enable) begin
                        shift_q <= load_data;
                        state_q <= S_RUN;
                    end else begin
                        shift_q <= '0;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_max) begin
                        if (enable) begin
                            shift_q <= load_data;
                        end else begin
                            shift_q <= '0;
                            state_q <= S_IDLE;
                        end
                    end else if (bit_end) begin
                        shift_q <= {shift_q[30:0], 1'b0};
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    shift_q <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mclk_q     <= 1'b0;
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            underrun_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            mclk_q     <= ~mclk_q;
            level_q    <= level_d;
            underrun_q <= underrun_d;
            irq_q      <= enable && (level_d <= watermark);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

`ifdef I2S_TX_HOLD_LAST_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_q <= '0;
        end else if (pop) begin
            last_q <= rd_entry;
        end
    end
`endif

    // Storage is not reset; the pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign level    = level_q;
    assign underrun = underrun_q;
    assign irq      = irq_q;
    assign MCLK     = mclk_q;
    assign BCLK     = cnt_q[BCLK_DIV_LOG2];
    assign LRCLK    = cnt_q[BCLK_DIV_LOG2+5];
    assign SDIN     = shift_q[31];

endmodule
